// File: rtl/concat_pkg.sv
// Shared helpers for the chunk packer: where each chunk lands in the wide
// word, and how wide the chunk-count field has to be.
package concat_pkg;

  function automatic int slot_lsb(input int idx, input int w, input int n,
                                  input bit msb_first);
    return msb_first ? (n - 1 - idx) * w : idx * w;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/concat_slot.sv
// One-entry valid/ready holding register. A load always wins over a drain,
// so a back-to-back drain and reload keeps valid high with the new word.
module concat_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/concat_packer.sv
// Collects N chunks of W bits into one N*W-bit word, with a flush that
// emits a zero-padded partial word. The finished word sits in concat_slot.
module concat_packer
  import concat_pkg::*;
#(
  parameter int W         = 1,
  parameter int N         = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [N*W-1:0]         out_data,
  output logic [$clog2(N+1)-1:0] out_count,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int DW   = N * W;
  localparam int CW   = count_width(N);
  localparam int CNTW = $clog2(N);
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(N - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   acc_q, acc_d, merged;
  logic            slot_free, accept, complete, do_flush, load;
  logic [CW-1:0]   load_count;
  logic [DW+CW-1:0] slot_data;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (cnt_q != LAST_IDX) || slot_free;
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (cnt_q == LAST_IDX);
  // A flush never competes with a completing word; that word already carries
  // everything accumulated, so it simply takes precedence.
  assign do_flush  = flush && slot_free && !complete && ((cnt_q != '0) || accept);
  assign load      = complete || do_flush;

  always_comb begin
    merged = acc_q;
    if (accept) begin
      merged = acc_q | (DW'(in_data) << slot_lsb(int'(cnt_q), W, N, MSB_FIRST));
    end
  end

  always_comb begin
    load_count = CW'(cnt_q) + CW'(accept);
    if (complete) begin
      load_count = CW'(N);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (load) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNTW'(1);
      acc_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  concat_slot #(
    .DW(DW + CW)
  ) u_slot (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .data_i  ({load_count, merged}),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (slot_data)
  );

  assign {out_count, out_data} = slot_data;

endmodule

// File: tb/tb_concat_packer.sv
// Directed checks across several packer configurations, then a randomized
// run on a 4x4 instance compared against a queue-based word model.
module tb_concat_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   nAsserts = 0;
  int   nFails   = 0;

  // A: W=1 N=2 MSB first
  logic [0:0]  aInData;
  logic        aInValid, aInReady, aFlush, aOutValid, aOutReady;
  logic [1:0]  aOutData;
  logic [1:0]  aOutCount;
  // B: W=4 N=3 LSB first
  logic [3:0]  bInData;
  logic        bInValid, bInReady, bFlush, bOutValid, bOutReady;
  logic [11:0] bOutData;
  logic [1:0]  bOutCount;
  // C: W=4 N=3 MSB first
  logic [3:0]  cInData;
  logic        cInValid, cInReady, cFlush, cOutValid, cOutReady;
  logic [11:0] cOutData;
  logic [1:0]  cOutCount;
  // D: W=8 N=2 MSB first
  logic [7:0]  dInData;
  logic        dInValid, dInReady, dFlush, dOutValid, dOutReady;
  logic [15:0] dOutData;
  logic [1:0]  dOutCount;
  // E: W=4 N=4 MSB first
  logic [3:0]  eInData;
  logic        eInValid, eInReady, eFlush, eOutValid, eOutReady;
  logic [15:0] eOutData;
  logic [2:0]  eOutCount;

  concat_packer #(.W(1), .N(2), .MSB_FIRST(1'b1)) dutA (
    .clk(clk), .reset(reset), .in_data(aInData), .in_valid(aInValid), .in_ready(aInReady),
    .flush(aFlush), .out_data(aOutData), .out_count(aOutCount), .out_valid(aOutValid),
    .out_ready(aOutReady));
  concat_packer #(.W(4), .N(3), .MSB_FIRST(1'b0)) dutB (
    .clk(clk), .reset(reset), .in_data(bInData), .in_valid(bInValid), .in_ready(bInReady),
    .flush(bFlush), .out_data(bOutData), .out_count(bOutCount), .out_valid(bOutValid),
    .out_ready(bOutReady));
  concat_packer #(.W(4), .N(3), .MSB_FIRST(1'b1)) dutC (
    .clk(clk), .reset(reset), .in_data(cInData), .in_valid(cInValid), .in_ready(cInReady),
    .flush(cFlush), .out_data(cOutData), .out_count(cOutCount), .out_valid(cOutValid),
    .out_ready(cOutReady));
  concat_packer #(.W(8), .N(2), .MSB_FIRST(1'b1)) dutD (
    .clk(clk), .reset(reset), .in_data(dInData), .in_valid(dInValid), .in_ready(dInReady),
    .flush(dFlush), .out_data(dOutData), .out_count(dOutCount), .out_valid(dOutValid),
    .out_ready(dOutReady));
  concat_packer #(.W(4), .N(4), .MSB_FIRST(1'b1)) dutE (
    .clk(clk), .reset(reset), .in_data(eInData), .in_valid(eInValid), .in_ready(eInReady),
    .flush(eFlush), .out_data(eOutData), .out_count(eOutCount), .out_valid(eOutValid),
    .out_ready(eOutReady));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic pairA(input logic x, input logic y, input logic [1:0] exp);
    @(negedge clk); aInValid = 1'b1; aInData = x;
    @(negedge clk); aInData = y;
    @(negedge clk); aInValid = 1'b0;
    checkOutput("A valid", aOutValid, 1);
    checkOutput("A data", aOutData, exp);
    checkOutput("A count", aOutCount, 2);
  endtask

  // Reference model for instance E: the chunks gathered since the last word.
  logic [3:0]  pend[$];
  logic        mValid;
  logic [15:0] mWord;
  int          mCount;

  function automatic logic [15:0] packWord();
    logic [15:0] word = '0;
    foreach (pend[i]) word = (word << 4) | 16'(pend[i]);
    return word << (4 * (4 - pend.size()));
  endfunction

  task automatic applyStimulus();
    logic slotFree, ready;
    @(negedge clk);
    checkOutput("E rnd valid", eOutValid, mValid);
    if (mValid) begin
      checkOutput("E rnd data", eOutData, mWord);
      checkOutput("E rnd count", eOutCount, mCount);
    end
    eInValid  = 1'($urandom_range(0, 1));
    eInData   = 4'($urandom);
    eFlush    = ($urandom_range(0, 7) == 0);
    eOutReady = ($urandom_range(0, 3) != 0);
    #1;
    slotFree = !mValid || eOutReady;
    ready    = (pend.size() != 3) || slotFree;
    checkOutput("E rnd inReady", eInReady, ready);
    if (eInValid && ready) pend.push_back(eInData);
    if (pend.size() == 4 || (eFlush && slotFree && pend.size() > 0)) begin
      mWord  = packWord();
      mCount = pend.size();
      mValid = 1'b1;
      pend.delete();
    end else if (mValid && eOutReady) begin
      mValid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    aInData = '0; aInValid = 0; aFlush = 0; aOutReady = 1;
    bInData = '0; bInValid = 0; bFlush = 0; bOutReady = 1;
    cInData = '0; cInValid = 0; cFlush = 0; cOutReady = 1;
    dInData = '0; dInValid = 0; dFlush = 0; dOutReady = 0;
    eInData = '0; eInValid = 0; eFlush = 0; eOutReady = 1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset A valid", aOutValid, 0);
    checkOutput("reset E valid", eOutValid, 0);
    checkOutput("reset E data", eOutData, 0);
    checkOutput("reset E count", eOutCount, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post-reset D inReady", dInReady, 1);
    checkOutput("post-reset D valid", dOutValid, 0);

    pairA(1'b1, 1'b0, 2'b10);
    pairA(1'b0, 1'b1, 2'b01);
    pairA(1'b1, 1'b1, 2'b11);

    @(negedge clk); bInValid = 1; bInData = 4'hA;
    @(negedge clk); bInData = 4'hB;
    @(negedge clk); bInData = 4'hC;
    @(negedge clk); bInValid = 0;
    checkOutput("B valid", bOutValid, 1);
    checkOutput("B data", bOutData, 12'hCBA);
    checkOutput("B count", bOutCount, 3);

    @(negedge clk); cInValid = 1; cInData = 4'h5;
    @(negedge clk); cInData = 4'h6;
    @(negedge clk); cInValid = 0; cFlush = 1;
    @(negedge clk); cFlush = 0;
    checkOutput("C flush valid", cOutValid, 1);
    checkOutput("C flush data", cOutData, 12'h560);
    checkOutput("C flush count", cOutCount, 2);
    @(negedge clk); cFlush = 1;
    @(negedge clk); cFlush = 0;
    checkOutput("C empty flush", cOutValid, 0);
    @(negedge clk);
    checkOutput("C empty flush later", cOutValid, 0);

    @(negedge clk); dInValid = 1; dInData = 8'h11;
    @(negedge clk); dInData = 8'h22;
    @(negedge clk); dInData = 8'h33; #1;
    checkOutput("D held valid", dOutValid, 1);
    checkOutput("D held data", dOutData, 16'h1122);
    checkOutput("D accept 0x33", dInReady, 1);
    @(negedge clk); dInData = 8'h44; #1;
    checkOutput("D stall 0x44", dInReady, 0);
    @(negedge clk); #1;
    checkOutput("D still stalled", dInReady, 0);
    checkOutput("D still held", dOutData, 16'h1122);
    checkOutput("D held count", dOutCount, 2);
    @(negedge clk); dOutReady = 1; #1;
    checkOutput("D unstall", dInReady, 1);
    @(negedge clk); dInValid = 0;
    checkOutput("D second valid", dOutValid, 1);
    checkOutput("D second data", dOutData, 16'h3344);
    checkOutput("D second count", dOutCount, 2);
    @(negedge clk);
    checkOutput("D no duplicate", dOutValid, 0);

    @(negedge clk); eInValid = 1; eInData = 4'h7;
    @(negedge clk); eInData = 4'h8; eFlush = 1;
    @(negedge clk); eInValid = 0; eFlush = 0;
    checkOutput("E flush+accept valid", eOutValid, 1);
    checkOutput("E flush+accept data", eOutData, 16'h7800);
    checkOutput("E flush+accept count", eOutCount, 2);

    @(negedge clk); eInValid = 1; eInData = 4'h9;
    @(negedge clk); eInData = 4'hA;
    @(negedge clk); eInValid = 0; reset = 0;
    @(negedge clk); reset = 1;
    checkOutput("E reset valid", eOutValid, 0);
    checkOutput("E reset data", eOutData, 0);
    checkOutput("E reset inReady", eInReady, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); eInValid = 1; eInData = 4'(i);
    end
    @(negedge clk); eInValid = 0;
    checkOutput("E after reset data", eOutData, 16'h1234);
    checkOutput("E after reset count", eOutCount, 4);
    checkOutput("E after reset valid", eOutValid, 1);

    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
    pend.delete();
    mValid = 1'b0;
    mWord  = '0;
    mCount = 0;
    for (int i = 0; i < 400; i++) applyStimulus();

    @(negedge clk);
    eInValid = 0; eFlush = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
